lock_keypad: RTL and testbench

- Keypad front end that sits directly upstream of the lock state machine and drives its open/close command inputs.
- Collects digit strokes and compares the entered sequence against a stored code.
- Correct code: one-cycle open pulse, then a close pulse after a relock delay.
- Repeated failures: entry is locked out for a fixed number of cycles.

---
 rtl/lock_keypad.sv | 107 ++++++++++
 tb/tb_lock_keypad.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lock_keypad.sv
// lock_keypad: keypad code entry that pulses the lock open/close inputs, with lockout after repeated failures
// Ports: clk, rst (synchronous, active-high); key_valid/key_digit stroke, key_enter submit,
//   key_cancel clear/early close; open, close one-cycle pulses; locked_out high during lockout;
//   fail_cnt consecutive failed attempts.
// Build option: define LOCK_KEYPAD_AUTO_RELOCK_EN to add the timed auto close RELOCK_CYCLES after open.
module lock_keypad #(
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*4-1:0] CODE = 16'h1234,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int RELOCK_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic key_valid,
  input  logic [3:0] key_digit,
  input  logic key_enter,
  input  logic key_cancel,
  output logic open,
  output logic close,
  output logic locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
  localparam int W = CODE_LEN * 4;
  localparam int CW = $clog2(CODE_LEN + 2);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
`ifdef LOCK_KEYPAD_AUTO_RELOCK_EN
  localparam int RW = $clog2(RELOCK_CYCLES) + 1;
  logic [RW-1:0] rel_tmr_q;
`endif
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD, LOCKOUT} state_t;
  state_t state_q;
  logic [W-1:0] dig_q, dig_d;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] lock_tmr_q;
  logic match_d, last_fail_d;
  // Buffer is zero outside ENTRY, so the first stroke in IDLE shifts into an empty buffer.
  assign dig_d = W'({dig_q, key_digit});
  // cnt saturates at CODE_LEN+1, which also records an overflowed entry.
  assign match_d = (cnt_q == CW'(CODE_LEN)) && (dig_q == CODE);
  assign last_fail_d = fail_cnt == FW'(MAX_FAIL - 1);
  always_ff @(posedge clk) begin
    open <= 1'b0;
    close <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      dig_q <= '0;
      cnt_q <= '0;
      lock_tmr_q <= '0;
      fail_cnt <= '0;
      locked_out <= 1'b0;
`ifdef LOCK_KEYPAD_AUTO_RELOCK_EN
      rel_tmr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, ENTRY:
          if (key_cancel) begin
            dig_q <= '0;
            cnt_q <= '0;
            state_q <= IDLE;
          end else if (key_enter) begin
            dig_q <= '0;
            cnt_q <= '0;
            if (match_d) begin
              open <= 1'b1;
              fail_cnt <= '0;
              state_q <= HOLD;
`ifdef LOCK_KEYPAD_AUTO_RELOCK_EN
              rel_tmr_q <= RW'(RELOCK_CYCLES - 1);
`endif
            end else if (last_fail_d) begin
              fail_cnt <= FW'(MAX_FAIL);
              locked_out <= 1'b1;
              lock_tmr_q <= LW'(LOCKOUT_CYCLES - 1);
              state_q <= LOCKOUT;
            end else begin
              fail_cnt <= fail_cnt + 1'b1;
              state_q <= IDLE;
            end
          end else if (key_valid) begin
            dig_q <= dig_d;
            cnt_q <= (cnt_q == CW'(CODE_LEN + 1)) ? cnt_q : cnt_q + 1'b1;
            state_q <= ENTRY;
          end
        HOLD:
          if (key_cancel) begin
            close <= 1'b1;
            state_q <= IDLE;
          end
`ifdef LOCK_KEYPAD_AUTO_RELOCK_EN
          else if (rel_tmr_q == '0) begin
            close <= 1'b1;
            state_q <= IDLE;
          end else rel_tmr_q <= rel_tmr_q - 1'b1;
`endif
        default:
          if (lock_tmr_q == '0) begin
            locked_out <= 1'b0;
            fail_cnt <= '0;
            state_q <= IDLE;
          end else lock_tmr_q <= lock_tmr_q - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_keypad.sv
// tb_lock_keypad: directed and randomized keypad stimulus checked against a queue-based reference model
module tb_lock_keypad;
  localparam int CODE_LEN = 4;
  localparam logic [15:0] CODE = 16'h1234;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT_CYCLES = 64;
  localparam int RELOCK_CYCLES = 32;
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_valid = 1'b0, key_enter = 1'b0, key_cancel = 1'b0;
  logic [3:0] key_digit = '0;
  logic open, close, locked_out;
  logic [FW-1:0] fail_cnt;
  int checks = 0, errors = 0;
  logic [3:0] q[$];
  logic [15:0] cv;
  bit hold, lock, e_open, e_close;
  int fails, relock_at, lock_end, n;
  lock_keypad #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RELOCK_CYCLES(RELOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_cancel(key_cancel), .open(open), .close(close),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask
  task automatic model(input bit v, input logic [3:0] d, input bit e, input bit c);
    bit m;
    e_open = 0;
    e_close = 0;
    if (rst) begin
      q.delete();
      hold = 0;
      lock = 0;
      fails = 0;
    end else if (lock) begin
      if (n == lock_end) begin
        lock = 0;
        fails = 0;
      end
    end else if (hold) begin
      if (c) begin
        e_close = 1;
        hold = 0;
      end
`ifdef LOCK_KEYPAD_AUTO_RELOCK_EN
      else if (n == relock_at) begin
        e_close = 1;
        hold = 0;
      end
`endif
    end else if (c) q.delete();
    else if (e) begin
      m = q.size() == CODE_LEN;
      for (int i = 0; i < CODE_LEN; i++)
        if (m && q[i] != cv[(CODE_LEN-1-i)*4 +: 4]) m = 0;
      q.delete();
      if (m) begin
        e_open = 1;
        fails = 0;
        hold = 1;
        relock_at = n + RELOCK_CYCLES;
      end else begin
        fails++;
        if (fails == MAX_FAIL) begin
          lock = 1;
          lock_end = n + LOCKOUT_CYCLES;
        end
      end
    end else if (v) q.push_back(d);
  endtask
  task automatic step(input bit v = 0, input logic [3:0] d = 0, input bit e = 0, input bit c = 0);
    key_valid = v;
    key_digit = d;
    key_enter = e;
    key_cancel = c;
    @(posedge clk);
    n++;
    model(v, d, e, c);
    #1;
    check("open", open, e_open);
    check("close", close, e_close);
    check("locked_out", locked_out, lock);
    check("fail_cnt", fail_cnt, fails);
    key_valid = 0;
    key_enter = 0;
    key_cancel = 0;
  endtask
  task automatic key(input logic [3:0] d);
    step(1, d);
  endtask
  task automatic enter();
    step(0, 0, 1);
  endtask
  task automatic cancel();
    step(0, 0, 0, 1);
  endtask
  task automatic idle(input int k);
    repeat (k) step();
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic type_code(input logic [31:0] w, input int len);
    for (int i = len - 1; i >= 0; i--) key(w[i*4 +: 4]);
  endtask
  initial begin
    int r;
    cv = CODE;
    n = 0;
    do_reset();
    do_reset();
    type_code(32'h1234, 4);
    enter();
    idle(40);
    cancel();
    idle(3);
    type_code(32'h1235, 4);
    enter();
    type_code(32'h12, 2);
    enter();
    enter();
    type_code(32'h1234, 4);
    enter();
    idle(70);
    type_code(32'h12344, 5);
    enter();
    key(9);
    cancel();
    type_code(32'h1234, 4);
    enter();
    idle(4);
    cancel();
    idle(40);
    type_code(32'h123, 3);
    step(1, 4, 1, 0);
    type_code(32'h123, 3);
    step(1, 4, 1, 1);
    type_code(32'h1234, 4);
    enter();
    idle(9);
    do_reset();
    idle(40);
    type_code(32'h1234, 4);
    enter();
    idle(200);
    cancel();
    idle(3);
    repeat (1500) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        type_code({16'h0, cv}, CODE_LEN);
        enter();
      end else if (r < 9) do_reset();
      else step($urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)),
                $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
